// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch predictor
package bp_pkg;

  typedef enum logic [1:0] {
    BP_COND = 2'b00,
    BP_JAL  = 2'b01,
    BP_JALR = 2'b10,
    BP_NONE = 2'b11
  } bp_kind_e;

  // Tag and target fields are held at a fixed maximum width; the top
  // zero-extends into them, so any PC_W up to 32 fits.
  localparam int BP_FIELD_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [BP_FIELD_W-1:0] tag;
    logic [BP_FIELD_W-1:0] target;
    bp_kind_e              kind;
  } btb_entry_t;

  localparam logic [1:0] PHT_INIT = 2'b01;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter next-state logic
module sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] nxt
);

  // Step toward 11 on inc, toward 00 otherwise, holding at either end.
  always_comb begin
    nxt = cnt;
    if (inc && (cnt != 2'b11)) begin
      nxt = cnt + 2'b01;
    end else if (!inc && (cnt != 2'b00)) begin
      nxt = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with bimodal/gshare 2-bit PHT
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int BTB_IDX_W = 4,
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6,
  parameter int MODE      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_W-1:0]      if_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [PC_W-1:0]      pred_target,
  output logic [PHT_IDX_W-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [PC_W-1:0]      upd_pc,
  input  logic [1:0]           upd_kind,
  input  logic                 upd_taken,
  input  logic [PC_W-1:0]      upd_target,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_mispredict,
  output logic [GHR_W-1:0]     ghr_out,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int BTB_N  = 1 << BTB_IDX_W;
  localparam int PHT_N  = 1 << PHT_IDX_W;
  localparam int TAG_SH = BTB_IDX_W + 2;

  btb_entry_t           btb [BTB_N];
  logic [1:0]           pht [PHT_N];
  logic [GHR_W-1:0]     ghr;
  logic [31:0]          n_br;
  logic [31:0]          n_mis;

  btb_entry_t           rd_e;
  logic [BTB_IDX_W-1:0] rd_bidx;
  logic [BTB_IDX_W-1:0] wr_bidx;
  logic [PHT_IDX_W-1:0] rd_bim;
  logic [PHT_IDX_W-1:0] rd_pidx;
  logic [1:0]           pht_nxt;
  logic                 upd_acc;
  logic                 unused_rd;

  // Zero-latency lookup: reads pre-update state, so a same-cycle write is
  // only visible from the next cycle on.
  always_comb begin
    rd_bidx     = if_pc[BTB_IDX_W+1:2];
    rd_bim      = PHT_IDX_W'(if_pc >> 2);
    rd_pidx     = (MODE == 1) ? (rd_bim ^ PHT_IDX_W'(ghr)) : rd_bim;
    rd_e        = btb[rd_bidx];
    pred_hit    = rd_e.valid && (rd_e.tag == 32'(if_pc >> TAG_SH));
    pred_taken  = pred_hit && ((rd_e.kind != BP_COND) || pht[rd_pidx][1]);
    pred_target = pred_taken ? rd_e.target[PC_W-1:0] : (if_pc + PC_W'(4));
    pred_idx    = rd_pidx;
  end

  assign unused_rd = ^(rd_e.target >> PC_W);

  assign wr_bidx = upd_pc[BTB_IDX_W+1:2];
  assign upd_acc = upd_valid && (upd_kind != BP_NONE);

  sat_counter2 u_pht_cnt (
    .cnt (pht[upd_idx]),
    .inc (upd_taken),
    .nxt (pht_nxt)
  );

  // Predictor state: reset wins over any update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_N; i++) btb[i] <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= PHT_INIT;
      ghr   <= '0;
      n_br  <= '0;
      n_mis <= '0;
    end else if (upd_acc) begin
      if (n_br != 32'hFFFF_FFFF) n_br <= n_br + 32'd1;
      if (upd_mispredict && (n_mis != 32'hFFFF_FFFF)) n_mis <= n_mis + 32'd1;
      if (upd_kind == BP_COND) begin
        pht[upd_idx] <= pht_nxt;
        ghr          <= (ghr << 1) | GHR_W'(upd_taken);
      end
      if (upd_taken) begin
        btb[wr_bidx] <= '{valid:  1'b1,
                          tag:    32'(upd_pc >> TAG_SH),
                          target: 32'(upd_target),
                          kind:   bp_kind_e'(upd_kind)};
      end
    end
  end

  assign ghr_out          = ghr;
  assign stat_branches    = n_br;
  assign stat_mispredicts = n_mis;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - randomized and directed check of branch_predictor_btb
module tb_branch_predictor_btb;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] if_pc;
  logic       upd_valid;
  logic [8:0] upd_pc;
  logic [1:0] upd_kind;
  logic       upd_taken;
  logic [8:0] upd_target;
  logic [5:0] upd_idx;
  logic       upd_mispredict;

  logic        hit_b, taken_b, hit_g, taken_g;
  logic [8:0]  tgt_b, tgt_g;
  logic [5:0]  idx_b, idx_g, ghr_b, ghr_g;
  logic [31:0] br_b, mis_b, br_g, mis_g;

  int n_asserts = 0;
  int n_fails   = 0;

  // reference model state
  bit          mv   [16];
  int unsigned mtag [16];
  int unsigned mtgt [16];
  int unsigned mkind[16];
  int unsigned mpht [64];
  int unsigned mghr, mbr, mmis;

  always #5 clk = ~clk;

  branch_predictor_btb #(.MODE(0)) dut_bim (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(hit_b), .pred_taken(taken_b), .pred_target(tgt_b), .pred_idx(idx_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_idx(upd_idx), .upd_mispredict(upd_mispredict),
    .ghr_out(ghr_b), .stat_branches(br_b), .stat_mispredicts(mis_b)
  );

  branch_predictor_btb #(.MODE(1)) dut_gsh (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(hit_g), .pred_taken(taken_g), .pred_target(tgt_g), .pred_idx(idx_g),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_idx(upd_idx), .upd_mispredict(upd_mispredict),
    .ghr_out(ghr_g), .stat_branches(br_g), .stat_mispredicts(mis_g)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void predict(input int m, input logic [8:0] pc,
                                  output logic hit, output logic taken,
                                  output logic [8:0] tgt, output logic [5:0] idx);
    int unsigned ip, b;
    ip    = pc;
    b     = (ip >> 2) % 16;
    idx   = 6'(((ip >> 2) % 64) ^ ((m == 1) ? mghr : 0));
    hit   = mv[b] && (mtag[b] == (ip >> 6));
    taken = hit && ((mkind[b] != 0) || (mpht[idx] >= 2));
    tgt   = taken ? 9'(mtgt[b]) : 9'((ip + 4) % 512);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mkind[i] = 0;
    end
    for (int i = 0; i < 64; i++) mpht[i] = 1;
    mghr = 0; mbr = 0; mmis = 0;
  endtask

  task automatic model_clock();
    int unsigned b;
    if (reset) begin
      model_reset();
    end else if (upd_valid && (upd_kind != 2'b11)) begin
      if (mbr != 32'hFFFF_FFFF) mbr++;
      if (upd_mispredict && (mmis != 32'hFFFF_FFFF)) mmis++;
      if (upd_kind == 2'b00) begin
        if (upd_taken) mpht[upd_idx] = (mpht[upd_idx] == 3) ? 3 : mpht[upd_idx] + 1;
        else           mpht[upd_idx] = (mpht[upd_idx] == 0) ? 0 : mpht[upd_idx] - 1;
        mghr = ((mghr * 2) + upd_taken) % 64;
      end
      if (upd_taken) begin
        b        = (int'(upd_pc) >> 2) % 16;
        mv[b]    = 1;
        mtag[b]  = int'(upd_pc) >> 6;
        mtgt[b]  = upd_target;
        mkind[b] = upd_kind;
      end
    end
  endtask

  task automatic compare();
    logic h, t;
    logic [8:0] tg;
    logic [5:0] ix;
    for (int m = 0; m < 2; m++) begin
      string p;
      p = (m == 1) ? "gsh" : "bim";
      predict(m, if_pc, h, t, tg, ix);
      check_eq({p, "_hit"},    (m == 1) ? hit_g   : hit_b,   h);
      check_eq({p, "_taken"},  (m == 1) ? taken_g : taken_b, t);
      check_eq({p, "_target"}, (m == 1) ? tgt_g   : tgt_b,   tg);
      check_eq({p, "_idx"},    (m == 1) ? idx_g   : idx_b,   ix);
      check_eq({p, "_ghr"},    (m == 1) ? ghr_g   : ghr_b,   mghr);
      check_eq({p, "_nbr"},    (m == 1) ? br_g    : br_b,    mbr);
      check_eq({p, "_nmis"},   (m == 1) ? mis_g   : mis_b,   mmis);
    end
  endtask

  // one clock: check outputs mid-cycle, then advance model with the DUT
  task automatic step();
    @(negedge clk);
    if (!reset) compare();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [8:0] pc, input logic [1:0] k,
                         input logic t, input logic [8:0] tg, input logic [5:0] ix,
                         input logic mis);
    upd_valid = v; upd_pc = pc; upd_kind = k; upd_taken = t;
    upd_target = tg; upd_idx = ix; upd_mispredict = mis;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [8:0] last_pc;
    reset = 1'b1;
    if_pc = 9'h040;
    set_upd(1'b0, 9'h0, 2'b00, 1'b0, 9'h0, 6'h0, 1'b0);
    model_reset();

    // reset values
    do_reset();
    check_eq("rst_hit", hit_b, 1'b0);
    check_eq("rst_taken", taken_b, 1'b0);
    check_eq("rst_target", tgt_b, 9'h044);
    check_eq("rst_idx", idx_b, 6'h10);
    check_eq("rst_nbr", br_b, 32'd0);

    // same-cycle conflict and first bimodal training
    set_upd(1'b1, 9'h040, 2'b00, 1'b1, 9'h010, 6'h10, 1'b0);
    #1;
    check_eq("conflict_old_hit", hit_b, 1'b0);
    step();
    set_upd(1'b0, 9'h0, 2'b00, 1'b0, 9'h0, 6'h0, 1'b0);
    #1;
    check_eq("train1_hit", hit_b, 1'b1);
    check_eq("train1_taken", taken_b, 1'b1);
    check_eq("train1_target", tgt_b, 9'h010);

    // saturate at 11, then one not-taken still predicts taken
    set_upd(1'b1, 9'h040, 2'b00, 1'b1, 9'h010, 6'h10, 1'b0);
    step(); step();
    upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    #1;
    check_eq("nt1_taken", taken_b, 1'b1);
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    #1;
    check_eq("nt2_hit", hit_b, 1'b1);
    check_eq("nt2_taken", taken_b, 1'b0);
    check_eq("nt2_target", tgt_b, 9'h044);

    // aliasing JAL replaces the entry
    set_upd(1'b1, 9'h080, 2'b01, 1'b1, 9'h100, 6'h20, 1'b0);
    step();
    upd_valid = 1'b0;
    #1;
    check_eq("alias_old_hit", hit_b, 1'b0);
    if_pc = 9'h080;
    step();
    check_eq("alias_new_taken", taken_b, 1'b1);
    check_eq("alias_new_target", tgt_b, 9'h100);

    // next-PC wrap at the top of the address space
    if_pc = 9'h1FC;
    step();
    check_eq("wrap_target", tgt_b, 9'h000);

    // gshare index folding
    do_reset();
    set_upd(1'b1, 9'h0C0, 2'b00, 1'b1, 9'h020, 6'h30, 1'b0);
    step(); step(); step();
    upd_valid = 1'b0;
    if_pc = 9'h040;
    #1;
    check_eq("gsh_ghr", ghr_g, 6'h07);
    check_eq("gsh_idx", idx_g, 6'h17);
    check_eq("bim_idx_fixed", idx_b, 6'h10);

    // stats, then reset mid-run with an update presented
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_upd(1'b1, 9'h040, 2'b00, 1'b1, 9'h010, 6'h10, (i == 1 || i == 3));
      step();
    end
    upd_valid = 1'b0;
    #1;
    check_eq("stat_br5", br_b, 32'd5);
    check_eq("stat_mis2", mis_b, 32'd2);
    set_upd(1'b1, 9'h040, 2'b00, 1'b1, 9'h010, 6'h10, 1'b1);
    do_reset();
    upd_valid = 1'b0;
    #1;
    check_eq("rstmid_nbr", br_b, 32'd0);
    check_eq("rstmid_nmis", mis_b, 32'd0);
    check_eq("rstmid_hit", hit_b, 1'b0);

    // randomized traffic against the model
    last_pc = 9'h040;
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      upd_valid      = 1'($urandom_range(0, 1));
      upd_pc         = 9'($urandom_range(0, 127) << 2);
      upd_kind       = 2'($urandom_range(0, 3));
      upd_taken      = 1'($urandom_range(0, 1));
      upd_target     = 9'($urandom);
      upd_idx        = ($urandom_range(0, 1) == 1) ? 6'(upd_pc >> 2) : 6'($urandom);
      upd_mispredict = 1'($urandom_range(0, 1));
      if_pc          = ($urandom_range(0, 1) == 1) ? last_pc : 9'($urandom_range(0, 127) << 2);
      last_pc        = upd_pc;
      step();
    end
    reset = 1'b0;
    upd_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
